// File: rtl/result_tx.sv
// result_tx: queues 32-bit nonces and frames each as header, 4 nonce bytes (LSB first), XOR checksum.
module result_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] HEADER = 8'h52
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_result,
  input  logic [31:0]                   result_data,
  output logic [7:0]                    tx_data,
  output logic                          new_tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_nx;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0] frame;
  logic [2:0] idx;
  logic [7:0] last_byte, cur_byte;
  logic full, pop, push;
  assign full = count == CW'(FIFO_DEPTH);
  assign pop = state == IDLE && count != '0;
  assign push = new_result && (!full || pop);
  assign fifo_count = count;
  assign busy = state != IDLE || count != '0;
  assign new_tx_data = state == SEND && !tx_busy;
  assign tx_data = new_tx_data ? cur_byte : last_byte;
  always_comb begin
    cur_byte = idx == 3'd0 ? HEADER :
               idx == 3'd1 ? frame[7:0] :
               idx == 3'd2 ? frame[15:8] :
               idx == 3'd3 ? frame[23:16] :
               idx == 3'd4 ? frame[31:24] :
               frame[7:0] ^ frame[15:8] ^ frame[23:16] ^ frame[31:24];
    state_nx = state == IDLE ? (pop ? SEND : IDLE) :
               state == SEND ? (tx_busy ? SEND : GAP) :
               (idx == 3'd5 ? IDLE : SEND);
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= result_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      frame <= '0;
      idx <= '0;
      last_byte <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        frame <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        idx <= '0;
      end
      if (new_result && !push) overflow <= 1'b1;
      if (new_tx_data) last_byte <= cur_byte;
      if (state == GAP && idx != 3'd5) idx <= idx + 3'd1;
    end
  end
endmodule

// File: tb/tb_result_tx.sv
// tb_result_tx: scoreboard bench for result_tx; expected frame bytes queued at each result pulse.
module tb_result_tx;
  logic clk = 0, rst = 1, new_result = 0, tx_busy = 0;
  logic [31:0] result_data = 0;
  logic [7:0] tx_data;
  logic new_tx_data, overflow, busy;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0, cyc = 0, nstrobe = 0;
  logic prev = 0;
  logic [7:0] q[$];
  int strobe_cyc[$];
  result_tx dut (.clk(clk), .rst(rst), .new_result(new_result), .result_data(result_data),
                 .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
                 .fifo_count(fifo_count), .overflow(overflow), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) prev = 0;
    else begin
      if (new_tx_data) begin
        check("strobe_busy", tx_busy, 0);
        check("strobe_gap", prev, 0);
        check("sb_has_data", q.size() != 0, 1);
        if (q.size() != 0) check("tx_byte", tx_data, q.pop_front());
        strobe_cyc.push_back(cyc);
        nstrobe++;
      end
      prev = new_tx_data;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [31:0] d, input bit drop = 0);
    new_result = 1;
    result_data = d;
    if (!drop) begin
      q.push_back(8'h52);
      q.push_back(d[7:0]);
      q.push_back(d[15:8]);
      q.push_back(d[23:16]);
      q.push_back(d[31:24]);
      q.push_back(d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
    end
    tick();
    new_result = 0;
  endtask
  task automatic wait_n(input int k);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (nstrobe >= k) break;
    end
    check("wait_strobe", nstrobe >= k, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 600 && q.size() != 0; i++) tick();
    check("drain", q.size(), 0);
    repeat (3) tick();
  endtask
  task automatic do_reset();
    tick();
    rst = 1;
    tick();
    rst = 0;
    q.delete();
  endtask
  initial begin
    int n0, k0, base, r;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx_data", tx_data, 0);
    check("rst_strobe", new_tx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 0;
    repeat (2) tick();
    k0 = strobe_cyc.size();
    n0 = cyc;
    pulse(32'h12345678);
    drain();
    check("t1_strobes", strobe_cyc.size() - k0, 6);
    for (int i = 0; i < 6; i++)
      if (k0 + i < strobe_cyc.size()) check("t1_latency", strobe_cyc[k0 + i] - n0, 2 + 2 * i);
    base = nstrobe;
    tick();
    n0 = cyc;
    pulse(32'h0BADF00D);
    while (cyc < n0 + 13) @(negedge clk);
    check("busy_last_gap", busy, 1);
    @(negedge clk);
    check("busy_idle", busy, 0);
    drain();
    base = nstrobe;
    pulse(32'hA1B2C3D4);
    wait_n(base + 1);
    tx_busy = 1;
    repeat (20) tick();
    check("hold_strobes", nstrobe, base + 1);
    tx_busy = 0;
    r = cyc;
    wait_n(base + 2);
    check("release_cycle", strobe_cyc[strobe_cyc.size() - 1], r);
    drain();
    tx_busy = 1;
    tick();
    for (int i = 0; i < 5; i++) pulse(32'h11110000 + i);
    @(negedge clk);
    check("burst_count", fifo_count, 4);
    check("burst_ovf0", overflow, 0);
    tick();
    pulse(32'hDEADBEEF, 1);
    @(negedge clk);
    check("burst_ovf1", overflow, 1);
    check("burst_count2", fifo_count, 4);
    tick();
    tx_busy = 0;
    drain();
    do_reset();
    @(negedge clk);
    check("ovf_cleared", overflow, 0);
    tick();
    tx_busy = 1;
    for (int i = 0; i < 5; i++) pulse(32'h22220000 + i);
    @(negedge clk);
    check("full_count", fifo_count, 4);
    tick();
    tx_busy = 0;
    base = nstrobe;
    wait_n(base + 6);
    tick();
    pulse(32'hCAFEF00D);
    @(negedge clk);
    check("pushpop_count", fifo_count, 4);
    check("pushpop_ovf", overflow, 0);
    drain();
    pulse(32'hFFFFFFFF);
    drain();
    pulse(32'h00000001);
    drain();
    base = nstrobe;
    pulse(32'h12345678);
    wait_n(base + 3);
    rst = 1;
    q.delete();
    tick();
    rst = 0;
    @(negedge clk);
    check("abort_strobe", new_tx_data, 0);
    check("abort_tx_data", tx_data, 0);
    check("abort_busy", busy, 0);
    check("abort_count", fifo_count, 0);
    base = nstrobe;
    repeat (20) tick();
    check("abort_silent", nstrobe, base);
    pulse(32'h5A5AA5A5);
    drain();
    check("fresh_frame", nstrobe, base + 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
